// File: rtl/rtc_esclavo_bus.sv
// rtc_esclavo_bus
// Responder end of the multiplexed 8-bit RTC bus. It latches an address on
// address-phase writes and updates a small BCD register file on data-phase
// writes. During read strobes it drives the shared bus combinationally from
// the register file. A free-running seconds timebase advances seg/min/hora
// while control.run is set.
//
// Ports
//   clk           system clock, all state on posedge
//   reset         asynchronous reset, active low
//   leerdato      read strobe, active low
//   escribirdato  write strobe, active low
//   AD            phase select: 0 = address, 1 = data
//   salient       shared address/data bus (driven only during reads)
//   irq_seg       one-cycle pulse on every seconds increment
//
// Register map (BCD)
//   0x00 seg  0x01 min  0x02 hora  0x03 dia  0x04 mes  0x05 anio
//   0x06 control (bit0 run)  0x07 status (bit0 conflict, bit1 seconds)
module rtc_esclavo_bus #(
  parameter int unsigned CICLOS_SEG = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       leerdato,
  input  logic       escribirdato,
  input  logic       AD,
  inout  wire  [7:0] salient,
  output logic       irq_seg
);

  localparam int PW = (CICLOS_SEG > 1) ? $clog2(CICLOS_SEG) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CICLOS_SEG - 1);

  logic [7:0]    dir;
  logic [7:0]    seg, min, hora, dia, mes, anio, control, status;
  logic [7:0]    status_nx;
  logic [PW-1:0] pre;

  logic          esc_hist;
  // Cleared by reset and set once the write strobe has been seen high, so a
  // strobe that was already low when reset was released is not taken as an
  // event.
  logic          esc_armed;

  logic          wr_evt, wr_addr, wr_data, conflict, tick, run;
  logic [7:0]    we;
  logic [7:0]    seg_inc, min_inc, hora_inc;
  logic          c_seg, c_min, c_hora;
  logic [7:0]    rdata;
  logic          drive;

  // Returns {carry, next} for a BCD counter that wraps to 00 after tope.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] tope);
    if (v == tope)
      return {1'b1, 8'h00};
    else if (v[3:0] == 4'h9)
      return {1'b0, v[7:4] + 4'h1, 4'h0};
    else
      return {1'b0, v[7:4], v[3:0] + 4'h1};
  endfunction

  assign run      = control[0];
  assign tick     = run && (pre == PRE_MAX);
  assign wr_evt   = !escribirdato && esc_hist && esc_armed;
  assign wr_addr  = wr_evt && !AD;
  assign wr_data  = wr_evt && AD;
  assign conflict = !leerdato && !escribirdato;

  assign {c_seg,  seg_inc}  = bcd_inc(seg,  8'h59);
  assign {c_min,  min_inc}  = bcd_inc(min,  8'h59);
  assign {c_hora, hora_inc} = bcd_inc(hora, 8'h23);

  always_comb begin
    we = '0;
    for (int k = 0; k < 8; k++)
      we[k] = wr_data && (dir == 8'(k));
  end

  // Set conditions are applied after the write so they win for their bit.
  always_comb begin
    status_nx    = we[7] ? salient : status;
    status_nx[0] = status_nx[0] | conflict;
    status_nx[1] = status_nx[1] | tick;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir       <= 8'h00;
      seg       <= 8'h00;
      min       <= 8'h00;
      hora      <= 8'h00;
      dia       <= 8'h01;
      mes       <= 8'h01;
      anio      <= 8'h00;
      control   <= 8'h01;
      status    <= 8'h00;
      pre       <= '0;
      irq_seg   <= 1'b0;
      esc_hist  <= 1'b1;
      esc_armed <= 1'b0;
    end else begin
      esc_hist <= escribirdato;
      if (escribirdato)
        esc_armed <= 1'b1;

      irq_seg <= tick;

      if (wr_addr)
        dir <= salient;

      // Writing seg restarts the second so the new value lasts a full period.
      if (we[0])
        pre <= '0;
      else if (run)
        pre <= tick ? '0 : pre + 1'b1;

      // A write beats a tick or carry into the same register; carries out of
      // a written register still come from its pre-write value.
      if (we[0])
        seg <= salient;
      else if (tick)
        seg <= seg_inc;

      if (we[1])
        min <= salient;
      else if (tick && c_seg)
        min <= min_inc;

      if (we[2])
        hora <= salient;
      else if (tick && c_seg && c_min)
        hora <= hora_inc;

      if (we[3]) dia     <= salient;
      if (we[4]) mes     <= salient;
      if (we[5]) anio    <= salient;
      if (we[6]) control <= salient;

      status <= status_nx;
    end
  end

  always_comb begin
    case (dir)
      8'h00:   rdata = seg;
      8'h01:   rdata = min;
      8'h02:   rdata = hora;
      8'h03:   rdata = dia;
      8'h04:   rdata = mes;
      8'h05:   rdata = anio;
      8'h06:   rdata = control;
      8'h07:   rdata = status;
      default: rdata = 8'h00;
    endcase
  end

  // Never drive while a write strobe is low: the master owns the bus then.
  assign drive   = !leerdato && AD && escribirdato && reset;
  assign salient = drive ? rdata : 8'hzz;

endmodule

// File: tb/tb_rtc_esclavo_bus.sv
module tb_rtc_esclavo_bus;

  logic       clk = 1'b0;
  logic       reset, leerdato, escribirdato, AD, irq_seg;
  logic       tb_oe;
  logic [7:0] tb_dat;
  wire  [7:0] salient;

  int n_run  = 0;
  int n_fail = 0;

  logic [7:0] v;
  logic [7:0] exp_map [8];
  int cnt, first;

  rtc_esclavo_bus #(.CICLOS_SEG(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .leerdato     (leerdato),
    .escribirdato (escribirdato),
    .AD           (AD),
    .salient      (salient),
    .irq_seg      (irq_seg)
  );

  assign salient = tb_oe ? tb_dat : 8'hzz;

  // Undriven bus floats to 0xFF so hi-Z is observable.
  generate
    for (genvar g = 0; g < 8; g++) begin : g_pu
      pullup (salient[g]);
    end
  endgenerate

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, want);
    end
  endtask

  task automatic wr(input logic a_d, input logic [7:0] val);
    @(negedge clk);
    AD = a_d; tb_dat = val; tb_oe = 1'b1; escribirdato = 1'b0;
    @(negedge clk);
    escribirdato = 1'b1; tb_oe = 1'b0;
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] val);
    wr(1'b0, a);
    wr(1'b1, val);
  endtask

  task automatic rd(output logic [7:0] val);
    @(negedge clk);
    AD = 1'b1; leerdato = 1'b0;
    #1 val = salient;
    leerdato = 1'b1;
  endtask

  task automatic rd_reg(input logic [7:0] a, output logic [7:0] val);
    wr(1'b0, a);
    rd(val);
  endtask

  task automatic watch(input int n, output int c, output int f);
    c = 0; f = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      #1;
      if (irq_seg) begin
        c++;
        if (f == 0) f = i;
      end
    end
  endtask

  initial begin
    reset = 1'b0; leerdato = 1'b1; escribirdato = 1'b1; AD = 1'b0;
    tb_oe = 1'b0; tb_dat = 8'h00;

    // reset: read attempt during reset leaves the bus floating
    repeat (2) @(negedge clk);
    leerdato = 1'b0; AD = 1'b1;
    #1 check("rst_bus_z", salient, 8'hff);
    check("rst_irq", {7'b0, irq_seg}, 8'h00);
    leerdato = 1'b1;
    // write strobe held low across reset release must not produce an event
    escribirdato = 1'b0; tb_oe = 1'b1; tb_dat = 8'h42;
    @(negedge clk);
    reset = 1'b1;
    #1 check("rel_irq", {7'b0, irq_seg}, 8'h00);
    repeat (3) @(negedge clk);
    escribirdato = 1'b1; tb_oe = 1'b0;
    rd_reg(8'h03, v); check("rst_dia", v, 8'h01);
    rd_reg(8'h06, v); check("rst_ctrl", v, 8'h01);
    wr_reg(8'h06, 8'h00);
    rd_reg(8'h00, v); check("rst_held_wr", {4'h0, v[7:4]}, 8'h00);

    // write/read and out-of-range access
    wr_reg(8'h00, 8'h00);
    wr_reg(8'h07, 8'h00);
    wr_reg(8'h01, 8'h45);
    rd(v); check("wr_min", v, 8'h45);
    wr_reg(8'h09, 8'h77);
    rd(v); check("oor_read", v, 8'h00);
    exp_map = '{8'h00, 8'h45, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
    for (int a = 0; a < 8; a++) begin
      rd_reg(8'(a), v);
      check($sformatf("map_%0d", a), v, exp_map[a]);
    end

    // rollover 23:59:59 -> 00:00:00
    wr_reg(8'h02, 8'h23);
    wr_reg(8'h01, 8'h59);
    wr_reg(8'h00, 8'h59);
    wr_reg(8'h06, 8'h01);
    watch(5, cnt, first);
    check("roll_irq_cnt", 8'(cnt), 8'd1);
    check("roll_irq_at", 8'(first), 8'd4);
    wr(1'b1, 8'h00);
    rd_reg(8'h00, v); check("roll_seg", v, 8'h00);
    rd_reg(8'h01, v); check("roll_min", v, 8'h00);
    rd_reg(8'h02, v); check("roll_hora", v, 8'h00);
    rd_reg(8'h07, v); check("roll_status", v, 8'h02);

    // run control: frozen while stopped, full period after seg write
    wr_reg(8'h00, 8'h10);
    repeat (20) @(negedge clk);
    rd(v); check("stop_seg", v, 8'h10);
    wr_reg(8'h06, 8'h01);
    watch(4, cnt, first);
    check("run_irq_at", 8'(first), 8'd4);
    wr(1'b1, 8'h00);
    rd_reg(8'h00, v); check("run_seg", v, 8'h11);
    // resume from frozen prescaler count (2): tick after 2 cycles
    wr_reg(8'h06, 8'h01);
    watch(3, cnt, first);
    check("resume_irq_at", 8'(first), 8'd2);
    check("resume_irq_cnt", 8'(cnt), 8'd1);
    wr(1'b1, 8'h00);
    rd_reg(8'h00, v); check("resume_seg", v, 8'h12);

    // priority: seg write on a tick cycle
    wr_reg(8'h00, 8'h00);
    wr_reg(8'h06, 8'h01);
    wr(1'b0, 8'h00);
    wr(1'b1, 8'h30);
    #1 check("prio_irq", {7'b0, irq_seg}, 8'h01);
    watch(4, cnt, first);
    check("prio_next_tick", 8'(first), 8'd4);
    wr(1'b0, 8'h06);
    wr(1'b1, 8'h00);
    rd_reg(8'h00, v); check("prio_seg", v, 8'h32);

    // conflict: both strobes low, bus left floating, write still lands
    wr_reg(8'h07, 8'h00);
    rd(v); check("status_clr", v, 8'h00);
    wr(1'b0, 8'h03);
    @(negedge clk);
    AD = 1'b1; leerdato = 1'b0; escribirdato = 1'b0; tb_oe = 1'b0;
    #1 check("conf_bus_z", salient, 8'hff);
    @(negedge clk);
    leerdato = 1'b1; escribirdato = 1'b1;
    rd_reg(8'h07, v); check("conf_status", v, 8'h01);
    rd_reg(8'h03, v); check("conf_wr_kept", v, 8'hff);
    // status write colliding with a conflict: set bit wins
    wr_reg(8'h07, 8'h00);
    rd(v); check("status_clr2", v, 8'h00);
    @(negedge clk);
    AD = 1'b1; tb_dat = 8'h00; tb_oe = 1'b1; escribirdato = 1'b0; leerdato = 1'b0;
    @(negedge clk);
    escribirdato = 1'b1; leerdato = 1'b1; tb_oe = 1'b0;
    rd(v); check("status_set_wins", v, 8'h01);

    // held write strobe: only the first sampled value is stored
    wr(1'b0, 8'h04);
    @(negedge clk);
    AD = 1'b1; tb_oe = 1'b1; tb_dat = 8'h11; escribirdato = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      tb_dat = 8'(8'h11 + i);
    end
    @(negedge clk);
    escribirdato = 1'b1; tb_oe = 1'b0;
    rd(v); check("held_strobe", v, 8'h11);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_esclavo_bus.md
# rtc_esclavo_bus

Responder end of the multiplexed 8-bit RTC bus: it decodes the address/data phases driven by the FPGA-side bus master, keeps a small BCD real-time-clock register file, and drives the shared `salient` bus during read strobes. It is used as a synthesizable RTC model for simulation and board loop-back tests of the master controller. It also runs its own seconds timebase, so reads observe live time.

## Interface
- `CICLOS_SEG`, default 100_000_000: clk cycles per RTC second; must be ≥ 2.
- `clk`  input  1  system clock, all logic on posedge.
- `reset`  input  1  asynchronous, active-low reset.
- `leerdato`  input  1  read strobe, active low.
- `escribirdato`  input  1  write strobe, active low.
- `AD`  input  1  phase select: 0 = address phase, 1 = data phase.
- `salient`  inout  8  shared address/data bus.
- `irq_seg`  output  1  one-cycle pulse on every seconds increment.

## Operation
- Phase decode: a strobe "event" is the first posedge where the strobe is sampled low after being sampled high. A strobe held low gives exactly one event.
- Address write: on an `escribirdato` event with `AD`=0, `dir` <= `salient`.
- Data write: on an `escribirdato` event with `AD`=1, `regs[dir]` <= `salient` if `dir` ≤ 0x07. Otherwise the write is ignored.
- Read: while `leerdato`=0, `AD`=1, `escribirdato`=1 and `reset`=1, `salient` = `regs[dir]`. The drive is combinational from the current registers. Out-of-range `dir` reads 0x00. In all other conditions `salient` = 8'hzz.
- Register map (BCD):
  - 0x00 seg, 00–59.
  - 0x01 min, 00–59.
  - 0x02 hora, 00–23.
  - 0x03 dia, 0x04 mes, 0x05 anio: plain storage, no calendar logic.
  - 0x06 control: bit0 = run; other bits stored.
  - 0x07 status: bit0 = sticky bus-conflict, bit1 = sticky seconds flag. Written value replaces the register.
- Timebase: a prescaler counts 0..`CICLOS_SEG`-1 while run=1 and freezes while run=0. On wrap, the block pulses `irq_seg`, sets status bit1, and increments seg in BCD:
  - 59 → 00 carries to min.
  - min 59 → 00 carries to hora.
  - hora 23 → 00.
- Writing seg clears the prescaler in the same cycle.
- Conflict: `leerdato`=0 and `escribirdato`=0 sampled together sets status bit0. The bus is not driven. The write event is still processed.
- Priority: a data write to a time register in the same cycle as a tick/carry into that register takes the written value. Other registers still take the tick/carry. A write to status in the same cycle as a set condition: the set wins for the bit being set.
- Reset (async, `reset`=0) sets:
  - `dir` = 0x00.
  - seg, min, hora = 0x00.
  - dia = 0x01, mes = 0x01, anio = 0x00.
  - control = 0x01.
  - status = 0x00.
  - prescaler = 0.
  - `irq_seg` = 0.
  - strobe history = 1 (high).
  - `salient` = hi-Z.
- Reset asserted mid-strobe: the strobe must return high before a new event is recognised after release.

## Timing
- Write latency: register updated at the posedge that samples the strobe falling. Readable via `salient` from the next cycle.
- Read latency: combinational. Data is valid in the same cycle `leerdato` falls, so the master capturing at the next posedge sees the current contents.
- `irq_seg`: registered. High for exactly one cycle, coinciding with the cycle in which the new seg value is visible.
- Tick period: exactly `CICLOS_SEG` cycles while run=1. Clearing run then setting it resumes from the frozen prescaler count.
- No wait states. The master may issue back-to-back events on consecutive strobe pulses of ≥1 cycle low and ≥1 cycle high.

## Test plan
- Reset: `reset`=0 mid-read → `salient`=zz. After release, read 0x03 → 0x01, read 0x06 → 0x01, `irq_seg`=0.
- Write/read: address 0x01 then data 0x45, then read → 0x45. Address 0x09 then data 0x77, then read → 0x00, and regs 0x00–0x07 are unchanged.
- Rollover (`CICLOS_SEG`=4): set hora=23, min=59, seg=59 → after 4 cycles all read 0x00, `irq_seg` pulses once, status reads 0x02.
- Run control: write control=0x00, wait 20 cycles → seg unchanged. Write 0x01 → seg increments 4 cycles later.
- Conflict/priority: both strobes low with `AD`=1 → bus hi-Z and status bit0 set. Write seg=0x30 on a tick cycle → seg=0x30 and the prescaler restarts from 0.
- Held strobe: `escribirdato` low for 10 cycles with the bus changing each cycle → only the first-cycle value is stored.
